// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the scoreboard entry layout.
package pipe_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int LAT_W      = 2;
  localparam int PERF_W     = 32;

  // Issue-to-forwardable latencies presented on id_lat_i
  localparam logic [LAT_W-1:0] LAT_ALU  = 2'd0;
  localparam logic [LAT_W-1:0] LAT_LOAD = 2'd1;

  // One tracked register: busy until writeback/kill, cnt = cycles until forwardable
  typedef struct packed {
    logic             busy;
    logic [LAT_W-1:0] cnt;
  } sb_entry_t;
endpackage

// File: rtl/reg_scoreboard_if.sv
// ID/EX/WB hazard-tracking bundle between the pipeline and the register scoreboard.
interface reg_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int LAT_W    = 2,
  parameter int PERF_W   = 32
);
  logic                id_valid_i;
  logic [4:0]          id_rs1_i;
  logic [4:0]          id_rs2_i;
  logic                id_rs1_used_i;
  logic                id_rs2_used_i;
  logic [4:0]          id_rd_i;
  logic                id_rd_we_i;
  logic [LAT_W-1:0]    id_lat_i;
  logic                ex_kill_i;
  logic                wb_valid_i;
  logic [4:0]          wb_rd_i;
  logic                stall_o;
  logic                pc_en;
  logic                IF_ID_en;
  logic                ID_EX_flush;
  logic [NUM_REGS-1:0] busy_vec_o;
  logic [PERF_W-1:0]   stall_cnt_o;

  // Pipeline side: drives ID/EX/WB information, consumes the stall controls
  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_i, id_rd_we_i, id_lat_i, ex_kill_i, wb_valid_i, wb_rd_i,
    input  stall_o, pc_en, IF_ID_en, ID_EX_flush, busy_vec_o, stall_cnt_o
  );

  // Scoreboard side
  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_i, id_rd_we_i, id_lat_i, ex_kill_i, wb_valid_i, wb_rd_i,
    output stall_o, pc_en, IF_ID_en, ID_EX_flush, busy_vec_o, stall_cnt_o
  );
endinterface

// File: rtl/sb_entry.sv
// Busy flag and forwardable countdown for a single architectural register.
module sb_entry #(
  parameter int LAT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_set,
  input  logic [LAT_W-1:0] i_lat,
  input  logic             i_clear,
  input  logic             i_dec,
  output logic             o_busy,
  output logic [LAT_W-1:0] o_cnt
);
  logic             r_busy;
  logic [LAT_W-1:0] r_cnt;

  // New issue beats clear (kill/writeback), which beats the countdown
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_set) begin
      r_busy <= 1'b1;
      r_cnt  <= i_lat;
    end else if (i_clear) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_dec && r_busy && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_busy = r_busy;
  assign o_cnt  = r_cnt;
endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side register scoreboard: hazard decode, stall controls, last-issue
// tracking for EX kills, and a stall-cycle performance counter.
module reg_scoreboard
  import pipe_pkg::*;
#(
  parameter int NUM_REGS = pipe_pkg::NUM_REGS,
  parameter int LAT_W    = pipe_pkg::LAT_W,
  parameter int PERF_W   = pipe_pkg::PERF_W
) (
  input logic             clk,
  input logic             rst,
  reg_scoreboard_if.slave sb
);
  logic [NUM_REGS-1:0] w_busy;
  logic [LAT_W-1:0]    w_cnt [NUM_REGS];
  logic                w_hit1;
  logic                w_hit2;
  logic                w_stall;
  logic                w_issue;
  logic                w_kill_en;

  logic [REG_ADDR_W-1:0] r_last_rd;
  logic                  r_last_vld;
  logic [PERF_W-1:0]     r_stall_cnt;

  // x0 is hardwired and never tracked
  assign w_busy[0] = 1'b0;
  assign w_cnt[0]  = '0;

  // One entry per tracked register; kill and writeback share the clear input
  // because issue is the only thing that outranks either of them
  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_entry
      sb_entry #(.LAT_W(LAT_W)) u_entry (
        .clk     (clk),
        .rst     (rst),
        .i_set   (w_issue && (sb.id_rd_i == REG_ADDR_W'(gi))),
        .i_lat   (sb.id_lat_i),
        .i_clear ((w_kill_en && (r_last_rd == REG_ADDR_W'(gi))) ||
                  (sb.wb_valid_i && (sb.wb_rd_i == REG_ADDR_W'(gi)))),
        .i_dec   (1'b1),
        .o_busy  (w_busy[gi]),
        .o_cnt   (w_cnt[gi])
      );
    end
  endgenerate

  // Operand hazard decode: a busy source still counting down cannot be forwarded yet
  always_comb begin
    w_hit1 = sb.id_valid_i && sb.id_rs1_used_i && (sb.id_rs1_i != '0) &&
             w_busy[sb.id_rs1_i] && (w_cnt[sb.id_rs1_i] != '0);
    w_hit2 = sb.id_valid_i && sb.id_rs2_used_i && (sb.id_rs2_i != '0) &&
             w_busy[sb.id_rs2_i] && (w_cnt[sb.id_rs2_i] != '0);
    // rst gating keeps the controls at their idle values while reset is held
    w_stall   = (w_hit1 || w_hit2) && !rst;
    w_kill_en = sb.ex_kill_i && r_last_vld;
    // A kill means the ID instruction is on the wrong path, so it must not issue
    w_issue   = sb.id_valid_i && !w_stall && !sb.ex_kill_i && sb.id_rd_we_i &&
                (sb.id_rd_i != '0);
  end

  // Remember which entry went to EX this cycle so a later kill can retract it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_vld <= 1'b0;
      r_last_rd  <= '0;
    end else begin
      r_last_vld <= w_issue;
      if (w_issue) r_last_rd <= sb.id_rd_i;
    end
  end

  // Count stalled cycles; wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_stall_cnt <= '0;
    else if (w_stall) r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign sb.stall_o     = w_stall;
  assign sb.pc_en       = !w_stall;
  assign sb.IF_ID_en    = !w_stall;
  assign sb.ID_EX_flush = w_stall || (sb.ex_kill_i && !rst);
  assign sb.busy_vec_o  = w_busy;
  assign sb.stall_cnt_o = r_stall_cnt;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed pipeline scenarios plus
// random traffic, compared against a timestamp-based hazard model.
module tb_reg_scoreboard;
  import pipe_pkg::*;

  logic clk;
  logic rst;

  reg_scoreboard_if #(.NUM_REGS(32), .LAT_W(2), .PERF_W(32)) sbif ();

  reg_scoreboard #(.NUM_REGS(32), .LAT_W(2), .PERF_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sbif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Reference model: a register is busy until writeback/kill and is not
  // forwardable before cycle m_ready (issue cycle + 1 + latency).
  bit        m_busy  [32];
  int        m_ready [32];
  int        cyc;
  bit        m_last_vld;
  int        m_last_rd;
  bit [31:0] m_stall_cnt;

  bit        last_stall;
  bit        last_flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_busy[i]  = 1'b0;
      m_ready[i] = 0;
    end
    cyc         = 0;
    m_last_vld  = 1'b0;
    m_last_rd   = 0;
    m_stall_cnt = '0;
  endtask

  task automatic drive_idle();
    sbif.id_valid_i    = 1'b0;
    sbif.id_rs1_i      = '0;
    sbif.id_rs2_i      = '0;
    sbif.id_rs1_used_i = 1'b0;
    sbif.id_rs2_used_i = 1'b0;
    sbif.id_rd_i       = '0;
    sbif.id_rd_we_i    = 1'b0;
    sbif.id_lat_i      = '0;
    sbif.ex_kill_i     = 1'b0;
    sbif.wb_valid_i    = 1'b0;
    sbif.wb_rd_i       = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
  endtask

  // One pipeline cycle: drive, check at the falling edge, advance model at the rising edge
  task automatic step(input bit v, input logic [4:0] r1, input bit u1,
                      input logic [4:0] r2, input bit u2, input logic [4:0] rd,
                      input bit we, input logic [1:0] lat, input bit kill,
                      input bit wv, input logic [4:0] wrd, output bit stalled);
    bit        exp_stall;
    bit        issue;
    bit [31:0] exp_busy;
    sbif.id_valid_i    = v;
    sbif.id_rs1_i      = r1;
    sbif.id_rs1_used_i = u1;
    sbif.id_rs2_i      = r2;
    sbif.id_rs2_used_i = u2;
    sbif.id_rd_i       = rd;
    sbif.id_rd_we_i    = we;
    sbif.id_lat_i      = lat;
    sbif.ex_kill_i     = kill;
    sbif.wb_valid_i    = wv;
    sbif.wb_rd_i       = wrd;
    @(negedge clk);
    exp_stall = v && ((u1 && r1 != 0 && m_busy[r1] && cyc < m_ready[r1]) ||
                      (u2 && r2 != 0 && m_busy[r2] && cyc < m_ready[r2]));
    exp_busy = '0;
    for (int i = 1; i < 32; i++) exp_busy[i] = m_busy[i];
    chk("stall_o",     32'(sbif.stall_o),     32'(exp_stall));
    chk("pc_en",       32'(sbif.pc_en),       32'(!exp_stall));
    chk("IF_ID_en",    32'(sbif.IF_ID_en),    32'(!exp_stall));
    chk("ID_EX_flush", 32'(sbif.ID_EX_flush), 32'(exp_stall || kill));
    chk("busy_vec_o",  sbif.busy_vec_o,       exp_busy);
    chk("stall_cnt_o", sbif.stall_cnt_o,      m_stall_cnt);
    last_stall = sbif.stall_o;
    last_flush = sbif.ID_EX_flush;
    stalled    = exp_stall;
    @(posedge clk);
    issue = v && !exp_stall && !kill && we && rd != 0;
    if (wv && wrd != 0) begin
      m_busy[wrd]  = 1'b0;
      m_ready[wrd] = 0;
    end
    if (kill && m_last_vld) begin
      m_busy[m_last_rd]  = 1'b0;
      m_ready[m_last_rd] = 0;
    end
    if (issue) begin
      m_busy[rd]  = 1'b1;
      m_ready[rd] = cyc + 1 + int'(lat);
    end
    m_last_vld = issue;
    m_last_rd  = int'(rd);
    if (exp_stall) m_stall_cnt++;
    cyc++;
    #1;
  endtask

  // Present one instruction in ID until it leaves, returning the stall cycles it saw
  task automatic instr(input logic [4:0] r1, input bit u1, input logic [4:0] r2,
                       input bit u2, input logic [4:0] rd, input bit we,
                       input logic [1:0] lat, output int nstall);
    bit s;
    nstall = 0;
    for (int k = 0; k < 8; k++) begin
      step(1, r1, u1, r2, u2, rd, we, lat, 0, 0, 0, s);
      if (!s) return;
      nstall++;
    end
    chk("issue_timeout", 32'(nstall), 32'd0);
  endtask

  task automatic idle_wb(input bit wv, input logic [4:0] wrd);
    bit s;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, wv, wrd, s);
  endtask

  initial begin
    int n;
    bit s;
    rst = 1'b1;
    drive_idle();
    #2;
    do_reset();

    // Reset then idle
    chk("rst_busy_vec",  sbif.busy_vec_o, 32'd0);
    chk("rst_stall_cnt", sbif.stall_cnt_o, 32'd0);
    idle_wb(0, 0);
    idle_wb(0, 0);

    // add x4,x3,x2 ; lw x5,0x40(x1) ; sub x9,x5,x1 ; or x2,x7,x5
    instr(5'd3, 1, 5'd2, 1, 5'd4, 1, LAT_ALU, n);
    chk("add_stalls", 32'(n), 32'd0);
    instr(5'd1, 1, 5'd0, 0, 5'd5, 1, LAT_LOAD, n);
    chk("lw_stalls", 32'(n), 32'd0);
    instr(5'd5, 1, 5'd1, 1, 5'd9, 1, LAT_ALU, n);
    chk("sub_load_use_stalls", 32'(n), 32'd1);
    instr(5'd7, 1, 5'd5, 1, 5'd2, 1, LAT_ALU, n);
    chk("or_stalls", 32'(n), 32'd0);
    idle_wb(0, 0);
    chk("loaduse_stall_cnt", sbif.stall_cnt_o, 32'd1);

    // lw x1 ; lw x2 ; lw x4 ; add x3,x1,x2 -> no stall, then writebacks
    do_reset();
    instr(5'd0, 0, 5'd0, 0, 5'd1, 1, LAT_LOAD, n);
    instr(5'd0, 0, 5'd0, 0, 5'd2, 1, LAT_LOAD, n);
    instr(5'd0, 0, 5'd0, 0, 5'd4, 1, LAT_LOAD, n);
    instr(5'd1, 1, 5'd2, 1, 5'd3, 1, LAT_ALU, n);
    chk("add_after_loads_stalls", 32'(n), 32'd0);
    chk("loads_busy_bits", sbif.busy_vec_o & 32'h16, 32'h16);
    idle_wb(1, 5'd1);
    idle_wb(1, 5'd2);
    idle_wb(1, 5'd4);
    idle_wb(0, 0);
    chk("after_wb_busy_bits", sbif.busy_vec_o & 32'h16, 32'h0);

    // lw x0 then consumer of x0
    do_reset();
    instr(5'd0, 0, 5'd0, 0, 5'd0, 1, LAT_LOAD, n);
    instr(5'd0, 1, 5'd0, 1, 5'd8, 1, LAT_ALU, n);
    chk("x0_consumer_stalls", 32'(n), 32'd0);
    chk("x0_never_busy", 32'(sbif.busy_vec_o[0]), 32'd0);

    // lw x6 then kill in the next cycle, then a consumer of x6
    do_reset();
    instr(5'd1, 1, 5'd0, 0, 5'd6, 1, LAT_LOAD, n);
    step(1, 5'd1, 1, 5'd2, 1, 5'd8, 1, LAT_ALU, 1, 0, 0, s);
    chk("kill_cycle_flush", 32'(last_flush), 32'd1);
    instr(5'd6, 1, 5'd0, 0, 5'd10, 1, LAT_ALU, n);
    chk("after_kill_consumer_stalls", 32'(n), 32'd0);
    chk("after_kill_busy6", 32'(sbif.busy_vec_o[6]), 32'd0);

    // Same-cycle writeback and issue to x7, then a consumer stalls once
    do_reset();
    instr(5'd0, 0, 5'd0, 0, 5'd7, 1, LAT_ALU, n);
    step(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, LAT_LOAD, 0, 1, 5'd7, s);
    chk("waw_wb_busy7", 32'(sbif.busy_vec_o[7]), 32'd1);
    // Consumer of x7 while its count is 1, then reset in the middle of the stall
    sbif.id_valid_i    = 1'b1;
    sbif.id_rs1_i      = 5'd7;
    sbif.id_rs1_used_i = 1'b1;
    sbif.id_rs2_used_i = 1'b0;
    sbif.id_rd_i       = 5'd11;
    sbif.id_rd_we_i    = 1'b1;
    sbif.id_lat_i      = LAT_ALU;
    sbif.ex_kill_i     = 1'b1;
    sbif.wb_valid_i    = 1'b0;
    @(negedge clk);
    chk("waw_consumer_stall", 32'(sbif.stall_o), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_stall_o",  32'(sbif.stall_o),     32'd0);
    chk("midrst_pc_en",    32'(sbif.pc_en),       32'd1);
    chk("midrst_IF_ID_en", 32'(sbif.IF_ID_en),    32'd1);
    chk("midrst_flush",    32'(sbif.ID_EX_flush), 32'd0);
    chk("midrst_busy_vec", sbif.busy_vec_o,       32'd0);
    chk("midrst_stall_cnt", sbif.stall_cnt_o,     32'd0);
    drive_idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();

    // Random traffic against the model, registers limited to x0..x7 for dense hazards
    for (int t = 0; t < 400; t++) begin
      step($urandom_range(0, 3) != 0,
           5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)),
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Issue-side register scoreboard for the RV32I 5-stage pipeline; it is the writer of the hazard state that the ID-stage stall logic reads.
- Marks destination registers busy when an instruction issues (ID->EX), counts down until each result becomes forwardable, and clears entries at writeback or on an EX kill.
- Drives the pipeline stall controls (pc_en, IF_ID_en, ID_EX_flush) from the current ID-stage source operands.
- Keeps a stall-cycle performance counter.

Parameters:
- NUM_REGS, 32, architectural registers tracked; x0 is never tracked.
- LAT_W, 2, width of the per-register forwardable-countdown field.
- PERF_W, 32, width of the stall-cycle counter.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous, active-high reset
- id_valid_i  input  1  ID stage holds a valid instruction
- id_rs1_i  input  5  ID source register 1
- id_rs2_i  input  5  ID source register 2
- id_rs1_used_i  input  1  instruction reads rs1
- id_rs2_used_i  input  1  instruction reads rs2
- id_rd_i  input  5  ID destination register
- id_rd_we_i  input  1  instruction writes rd
- id_lat_i  input  LAT_W  cycles after issue before the result can be forwarded (ALU 0, load 1)
- ex_kill_i  input  1  instruction now in EX is squashed (branch redirect)
- wb_valid_i  input  1  writeback occurs this cycle
- wb_rd_i  input  5  writeback destination
- stall_o  output  1  ID must hold
- pc_en  output  1  PC update enable (~stall_o)
- IF_ID_en  output  1  IF/ID register enable (~stall_o)
- ID_EX_flush  output  1  insert bubble into EX (stall_o | ex_kill_i)
- busy_vec_o  output  NUM_REGS  registered busy bits; bit 0 is always 0
- stall_cnt_o  output  PERF_W  cycles with stall_o=1

Behaviour:
- State per register r (1..31): busy[r] and cnt[r][LAT_W-1:0].
- Also held: last_rd[4:0] and last_vld, which identify the entry issued in the previous cycle, i.e. the instruction now in EX.
- Reset (async): all busy=0, cnt=0, last_vld=0, stall_cnt_o=0. Outputs under reset: stall_o=0, pc_en=1, IF_ID_en=1, ID_EX_flush=0.
- Hit: hitN = id_valid_i & id_rsN_used_i & (id_rsN_i!=0) & busy[id_rsN_i] & (cnt[id_rsN_i]!=0).
- stall_o = hit1 | hit2. This is combinational from the ID inputs and registered state, so there is zero-cycle latency.
- Issue: issue = id_valid_i & ~stall_o & ~ex_kill_i & id_rd_we_i & (id_rd_i!=0). On issue at edge: busy[rd]=1, cnt[rd]=id_lat_i, last_rd=rd, last_vld=1. Otherwise last_vld=0.
- Countdown: every cycle, each busy entry with cnt!=0 decrements by 1 (saturate at 0). Issue overrides the decrement for the same rd (WAW: the newest latency wins).
- Writeback: wb_valid_i & wb_rd_i!=0 clears busy/cnt of wb_rd_i.
- Simultaneous issue and writeback to the same rd: issue wins, so the entry stays busy with the new cnt.
- Kill: ex_kill_i & last_vld clears busy/cnt of last_rd. Priority is issue > kill > writeback for the same register in one cycle. Kill also blocks issue of the ID instruction, since it is on the wrong path.
- Load-use example: lw x5 (lat 1) followed by sub using x5 gives exactly 1 stall cycle. An ALU result (lat 0) never stalls.
- A lw followed by an independent instruction and then a consumer gives 0 stalls, because cnt has already reached 0.
- stall_cnt_o increments on each cycle with stall_o=1 and wraps at 2^PERF_W.
- Reset asserted mid-stall: outputs return to the reset values immediately and all state is cleared.

Decomposition:
- Shared package pipe_pkg: REG_ADDR_W=5, NUM_REGS, LAT_ALU=0, LAT_LOAD=1, and a typedef sb_entry_t {busy, cnt}.
- Sub-module sb_entry: one register's busy/cnt update logic, with inputs set, lat, clear and dec. It is instantiated 31 times with generate. The top level holds the hit/stall decode, the last-issue tracking and the perf counter.

Test Plan:
- Reset then idle: busy_vec_o=0, pc_en=1, IF_ID_en=1, ID_EX_flush=0, stall_cnt_o=0.
- Sequence add x4,x3,x2 (lat 0), lw x5,0x40(x1) (lat 1), sub x9,x5,x1, or x2,x7,x5: exactly one cycle with stall_o=1, occurring while sub is in ID; or does not stall; stall_cnt_o=1.
- Sequence lw x1, lw x2, lw x4, add x3,x1,x2: no stall, because every count has reached 0; busy_vec_o bits 1, 2 and 4 set until each writeback clears them.
- Issue lw x0 with id_lat_i=1, then a consumer of x0: no stall, and busy_vec_o[0] stays 0.
- Issue lw x6 (lat 1) with ex_kill_i=1 the next cycle, then a consumer of x6 in ID: no stall, busy[6]=0, ID_EX_flush=1 during the kill cycle.
- Same-cycle wb_rd=7 and issue rd=7 with lat 1: busy[7]=1 and cnt=1 after the edge. Assert rst mid-stall: stall_o drops asynchronously and busy_vec_o=0.
